// File: rtl/mac_result_serializer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mac_result_serializer_pkg
// Description : Shared MAC definitions: default accumulator width, frame
//               header constant, serializer state encodings and a helper
//               that sizes the byte frame for a given accumulator width.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_result_serializer_pkg;

    // Default accumulator result width shared by the MAC blocks.
    localparam int c_mac_acc_w = 41;

    // Frame header byte that precedes every serialized result.
    localparam logic [7:0] c_mac_header = 8'hA5;

    // Serializer FSM state encodings.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2,
        ST_CHECK  = 2'd3
    } ser_state_t;

    // Number of whole bytes needed to carry a w-bit value.
    function automatic int mac_bytes(input int w);
        return (w + 7) / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_hold_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mac_hold_reg
// Description : One-entry holding buffer with a full flag. A write always
//               stores the data and marks the entry full (a simultaneous
//               read and write leaves it full with the new data); a read
//               alone empties it.
// Ports       : clk     - clock
//               rst_n   - asynchronous active-low reset (empties the entry)
//               i_wr    - store i_data
//               i_rd    - consume the stored entry
//               i_data  - data to store
//               o_data  - stored data
//               o_full  - entry holds valid data
// Revision    : 1.0 - initial release
// ============================================================================
module mac_hold_reg #(
    parameter int WIDTH = 41
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr,
    input  logic             i_rd,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full
);

    logic [WIDTH-1:0] r_data;
    logic             r_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_wr) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end else if (i_rd) begin
            r_full <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule
`default_nettype wire

// File: rtl/mac_result_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mac_result_serializer
// Description : Frames accumulator results into a byte stream:
//               0xA5 header, ceil(ACC_W/8) data bytes MSB first, then an
//               XOR checksum of the data bytes. One result may wait in a
//               pending slot while a frame is in flight; further results
//               are dropped and flagged via the sticky overrun output.
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous active-low reset
//               ena        - global enable, holds all state when low
//               acc_in     - accumulator result
//               acc_valid  - single-cycle strobe qualifying acc_in
//               byte_ready - downstream accepts byte_out
//               byte_out   - current frame byte (registered)
//               byte_valid - byte_out valid
//               byte_last  - byte_out is the checksum (final) byte
//               busy       - FSM not idle
//               overrun    - sticky: a result was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module mac_result_serializer
    import mac_result_serializer_pkg::*;
#(
    parameter int ACC_W = c_mac_acc_w
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [ACC_W-1:0] acc_in,
    input  logic             acc_valid,
    input  logic             byte_ready,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    output logic             byte_last,
    output logic             busy,
    output logic             overrun
);

    localparam int BYTES = mac_bytes(ACC_W);
    localparam int EXT_W = 8 * BYTES;
    localparam int CNT_W = $clog2(BYTES + 1);
    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(BYTES - 1);

    ser_state_t       r_state;
    ser_state_t       w_state_next;

    logic [EXT_W-1:0] r_shift;      // remaining data bytes, next one at the top
    logic [CNT_W-1:0] r_cnt;        // index of the data byte on byte_out
    logic [7:0]       r_byte_out;
    logic [7:0]       r_checksum;   // XOR of data bytes presented so far
    logic             r_overrun;

    logic             w_busy;
    logic             w_hs;
    logic             w_check_done;
    logic             w_load;
    logic             w_load_pend;
    logic             w_pend_wr;
    logic             w_pend_rd;
    logic             w_drop;
    logic             w_pend_full;
    logic [ACC_W-1:0] w_pend_data;
    logic [ACC_W-1:0] w_load_val;
    logic [EXT_W-1:0] w_load_ext;
    logic [7:0]       w_top;

    assign w_busy       = (r_state != ST_IDLE);
    assign w_hs         = w_busy && byte_ready && ena;
    assign w_check_done = (r_state == ST_CHECK) && w_hs;
    assign w_top        = r_shift[EXT_W-1 -: 8];

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_pend  = 1'b0;
        w_pend_wr    = 1'b0;
        w_pend_rd    = 1'b0;
        w_drop       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (ena && acc_valid) begin
                    w_state_next = ST_HEADER;
                    w_load       = 1'b1;
                end
            end
            ST_HEADER: begin
                if (w_hs) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_hs && (r_cnt == c_last_idx)) begin
                    w_state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // Chain straight into the next frame when work is queued,
                // the pending slot taking priority over a fresh strobe.
                if (w_hs) begin
                    if (w_pend_full) begin
                        w_state_next = ST_HEADER;
                        w_load       = 1'b1;
                        w_load_pend  = 1'b1;
                        w_pend_rd    = 1'b1;
                    end else if (acc_valid) begin
                        w_state_next = ST_HEADER;
                        w_load       = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Results arriving while a frame is in flight. At the end of a frame
        // a full slot is being drained, so a new strobe refills it; an empty
        // slot means the strobe is framed directly instead.
        if (ena && acc_valid && w_busy) begin
            if (w_check_done) begin
                if (w_pend_full) begin
                    w_pend_wr = 1'b1;
                end
            end else if (!w_pend_full) begin
                w_pend_wr = 1'b1;
            end else begin
                w_drop = 1'b1;
            end
        end
    end

    assign w_load_val = w_load_pend ? w_pend_data : acc_in;

    always_comb begin
        w_load_ext               = '0;
        w_load_ext[ACC_W-1:0]    = w_load_val;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: byte sequencing and incremental checksum
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_cnt      <= '0;
            r_byte_out <= 8'h00;
            r_checksum <= 8'h00;
            r_overrun  <= 1'b0;
        end else if (ena) begin
            if (w_load) begin
                r_shift    <= w_load_ext;
                r_cnt      <= '0;
                r_byte_out <= c_mac_header;
                r_checksum <= 8'h00;
            end else if (w_hs) begin
                case (r_state)
                    ST_HEADER: begin
                        r_byte_out <= w_top;
                        r_checksum <= r_checksum ^ w_top;
                        r_shift    <= r_shift << 8;
                    end
                    ST_DATA: begin
                        if (r_cnt == c_last_idx) begin
                            r_byte_out <= r_checksum;
                        end else begin
                            r_byte_out <= w_top;
                            r_checksum <= r_checksum ^ w_top;
                            r_shift    <= r_shift << 8;
                            r_cnt      <= r_cnt + CNT_W'(1);
                        end
                    end
                    ST_CHECK: begin
                        r_byte_out <= 8'h00;
                    end
                    default: begin
                    end
                endcase
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending result slot
    // ------------------------------------------------------------------
    mac_hold_reg #(
        .WIDTH (ACC_W)
    ) u_pending (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_wr   (w_pend_wr),
        .i_rd   (w_pend_rd),
        .i_data (acc_in),
        .o_data (w_pend_data),
        .o_full (w_pend_full)
    );

    assign byte_out   = r_byte_out;
    assign byte_valid = w_busy;
    assign byte_last  = (r_state == ST_CHECK);
    assign busy       = w_busy;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_mac_result_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mac_result_serializer
// Description : Scoreboard bench for mac_result_serializer. A frame-level
//               reference model queues the expected bytes of each frame it
//               starts; a monitor pops and compares on every handshake and
//               tracks busy/overrun/stall stability.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_result_serializer;

    localparam int ACC_W = 41;
    localparam int NB    = (ACC_W + 7) / 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ena;
    logic [ACC_W-1:0] acc_in;
    logic             acc_valid;
    logic             byte_ready;
    logic [7:0]       byte_out;
    logic             byte_valid;
    logic             byte_last;
    logic             busy;
    logic             overrun;

    always #5 clk = ~clk;

    mac_result_serializer #(
        .ACC_W (ACC_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .acc_in     (acc_in),
        .acc_valid  (acc_valid),
        .byte_ready (byte_ready),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_last  (byte_last),
        .busy       (busy),
        .overrun    (overrun)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] b;
        logic       last;
    } exp_t;

    exp_t             exp_q[$];
    logic [ACC_W-1:0] m_pend[$];
    int               m_left = 0;   // bytes of the current frame not yet accepted
    bit               m_ovr  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference: header, data bytes MSB first, XOR checksum.
    function automatic void start_frame(input logic [ACC_W-1:0] v);
        logic [8*NB-1:0] ext;
        logic [7:0]      cs;
        exp_t            e;
        ext = '0;
        ext[ACC_W-1:0] = v;
        cs = 8'h00;
        e.b = 8'hA5; e.last = 1'b0; exp_q.push_back(e);
        for (int i = 0; i < NB; i++) begin
            e.b    = ext[8*(NB-1-i) +: 8];
            e.last = 1'b0;
            cs     = cs ^ e.b;
            exp_q.push_back(e);
        end
        e.b = cs; e.last = 1'b1; exp_q.push_back(e);
        m_left = NB + 2;
    endfunction

    // Frame-level reference model, advanced on each clock edge.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_left = 0;
                m_pend.delete();
                m_ovr  = 1'b0;
                exp_q.delete();
            end else if (ena) begin
                if (m_left == 0) begin
                    if (acc_valid) start_frame(acc_in);
                end else begin
                    bit hs;
                    bit done;
                    hs   = byte_ready;
                    done = hs && (m_left == 1);
                    if (hs) m_left--;
                    if (done) begin
                        if (m_pend.size() > 0) begin
                            start_frame(m_pend.pop_front());
                            if (acc_valid) m_pend.push_back(acc_in);
                        end else if (acc_valid) begin
                            start_frame(acc_in);
                        end
                    end else if (acc_valid) begin
                        if (m_pend.size() == 0) m_pend.push_back(acc_in);
                        else                    m_ovr = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: compares DUT against the model away from the active edge.
    initial begin
        bit         stall;
        logic [7:0] sb;
        logic       sl;
        exp_t       e;
        stall = 1'b0;
        sb    = 8'h00;
        sl    = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_byte_out", byte_out, 0);
                chk("reset_byte_valid", byte_valid, 0);
                chk("reset_byte_last", byte_last, 0);
                chk("reset_busy", busy, 0);
                chk("reset_overrun", overrun, 0);
                stall = 1'b0;
            end else begin
                if (stall && byte_valid) begin
                    chk("stall_byte_stable", byte_out, sb);
                    chk("stall_last_stable", byte_last, sl);
                end
                chk("busy", busy, (m_left > 0));
                chk("byte_valid", byte_valid, (m_left > 0));
                chk("overrun", overrun, m_ovr);
                if (byte_valid && byte_ready && ena) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_byte: actual=%0h required=none at %0t", byte_out, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("byte_out", byte_out, e.b);
                        chk("byte_last", byte_last, e.last);
                    end
                end
                stall = byte_valid && !(byte_ready && ena);
                sb    = byte_out;
                sl    = byte_last;
            end
        end
    end

    task automatic drive(input logic v, input logic [ACC_W-1:0] d, input logic r, input logic e);
        acc_valid  = v;
        acc_in     = d;
        byte_ready = r;
        ena        = e;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((m_left > 0 || m_pend.size() > 0) && n < budget) begin
            drive(1'b0, '0, 1'b1, 1'b1);
            n++;
        end
        chk("drain_model_idle", (m_left == 0 && m_pend.size() == 0), 1);
        chk("drain_dut_idle", busy, 0);
    endtask

    // Strobe one result, then count busy cycles until it drains.
    // mode 0: ready high; mode 1: ready toggles starting low.
    task automatic run_frame(input logic [ACC_W-1:0] v, input int mode, output int cyc);
        int k;
        drive(1'b1, v, 1'b0, 1'b1);
        cyc = 0;
        k   = 0;
        while (busy && k < 60) begin
            drive(1'b0, '0, (mode == 0) ? 1'b1 : logic'(k % 2 == 1), 1'b1);
            cyc++;
            k++;
        end
    endtask

    logic [63:0] r64;
    int          cyc;

    initial begin
        rst_n      = 1'b1;
        ena        = 1'b0;
        acc_valid  = 1'b0;
        byte_ready = 1'b0;
        acc_in     = '0;
        #2 rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b1);
        chk("post_reset_busy", busy, 0);

        // Basic frame: A5 01 23 45 67 89 AB 22 back to back.
        run_frame(41'h1_23456789AB, 0, cyc);
        chk("basic_frame_cycles", cyc, 8);

        // Backpressure: same bytes, one handshake every other cycle.
        run_frame(41'h1_23456789AB, 1, cyc);
        chk("backpressure_frame_cycles", cyc, 16);

        // Back-to-back: second result during DATA chains with no bubble.
        drive(1'b1, 41'h1_23456789AB, 1'b0, 1'b1);
        cyc = 0;
        for (int i = 0; i < 3; i++) begin
            if (busy) cyc++;
            drive(1'b0, '0, 1'b1, 1'b1);
        end
        if (busy) cyc++;
        drive(1'b1, '0, 1'b1, 1'b1);
        while (busy && cyc < 40) begin
            drive(1'b0, '0, 1'b1, 1'b1);
            cyc++;
        end
        chk("back_to_back_cycles", cyc, 16);

        // Overrun: three strobes in one frame, third dropped.
        drive(1'b1, 41'h0_1111111111, 1'b0, 1'b1);
        drive(1'b1, 41'h0_2222222222, 1'b0, 1'b1);
        drive(1'b1, 41'h0_3333333333, 1'b0, 1'b1);
        chk("overrun_set", overrun, 1);
        wait_idle(100);
        run_frame(41'h0_0000000042, 0, cyc);
        chk("overrun_sticky", overrun, 1);

        // Reset during the third data byte.
        drive(1'b1, 41'h1_23456789AB, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 1'b1);
        chk("pre_reset_byte", byte_out, 8'h45);
        rst_n = 1'b0;
        #1;
        chk("async_reset_byte_out", byte_out, 0);
        chk("async_reset_valid", byte_valid, 0);
        chk("async_reset_last", byte_last, 0);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_overrun", overrun, 0);
        drive(1'b0, '0, 1'b1, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b1);
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b1, 1'b1);
        chk("after_reset_idle", busy, 0);
        run_frame(41'h0_00000000FF, 0, cyc);
        chk("after_reset_frame_cycles", cyc, 8);

        // Enable low for 5 cycles mid-frame; strobe while disabled is ignored.
        drive(1'b1, 41'h1_F0E1D2C3B4, 1'b0, 1'b1);
        cyc = 0;
        for (int i = 0; i < 3; i++) begin
            if (busy) cyc++;
            drive(1'b0, '0, 1'b1, 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            if (busy) cyc++;
            drive((i == 2), 41'h0_5555555555, 1'b1, 1'b0);
        end
        while (busy && cyc < 40) begin
            drive(1'b0, '0, 1'b1, 1'b1);
            cyc++;
        end
        chk("enable_frame_cycles", cyc, 13);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r64 = {$urandom(), $urandom()};
            drive(($urandom_range(0, 5) == 0), r64[ACC_W-1:0],
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) != 0));
        end
        wait_idle(200);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
